// File: rtl/tx_frame_sequencer.sv
// Link-layer TX framing sequencer: frames packets as STP / payload / END,
// fills the gaps with IDL and schedules periodic COM SKP SKP SKP ordered sets.
module tx_frame_sequencer #(
   parameter int SKP_INTERVAL = 64
) (
   input  logic       CLK,
   input  logic       RESET_L,
   input  logic       PKT_START,
   input  logic [7:0] PKT_LEN,
   input  logic       FIFO_EMPTY,
   input  logic [7:0] FIFO_DATA,
   output logic       FIFO_RD,
   output logic [3:0] CONTROL,
   output logic [7:0] Tx_Buffer,
   output logic       VALID,
   output logic       BUSY,
   output logic       PKT_DONE,
   output logic       PKT_ABORT
);

   localparam int CNT_W = $clog2(SKP_INTERVAL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);

   localparam logic [3:0] SYM_COM  = 4'd0;
   localparam logic [3:0] SYM_SKP  = 4'd2;
   localparam logic [3:0] SYM_STP  = 4'd3;
   localparam logic [3:0] SYM_END  = 4'd5;
   localparam logic [3:0] SYM_EDB  = 4'd6;
   localparam logic [3:0] SYM_IDL  = 4'd8;
   localparam logic [3:0] SYM_DATA = 4'd9;

   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_SKP0 = 4'd1;
   localparam logic [3:0] ST_SKP1 = 4'd2;
   localparam logic [3:0] ST_SKP2 = 4'd3;
   localparam logic [3:0] ST_SKP3 = 4'd4;
   localparam logic [3:0] ST_STP  = 4'd5;
   localparam logic [3:0] ST_DATA = 4'd6;
   localparam logic [3:0] ST_END  = 4'd7;
   localparam logic [3:0] ST_EDB  = 4'd8;

   logic [3:0]       state_r;
   logic [CNT_W-1:0] skp_cnt_r;
   logic             skp_pending_r;
   logic [7:0]       byte_cnt_r;
   logic [3:0]       control_r;
   logic [7:0]       tx_buffer_r;
   logic             valid_r;
   logic             busy_r;
   logic             pkt_done_r;
   logic             pkt_abort_r;

   logic [3:0]       state_nxt_s;
   logic [3:0]       ctl_nxt_s;
   logic [7:0]       byte_cnt_nxt_s;
   logic             pop_s;
   logic             skp_take_s;
   logic             wrap_s;
   logic             skp_req_s;

   // A wrap in the deciding cycle counts as a request, so SKP beats a coincident PKT_START
   assign wrap_s    = (skp_cnt_r == CNT_LAST);
   assign skp_req_s = skp_pending_r | wrap_s;

   // Next state and next symbol; state_r names the symbol currently on CONTROL
   always_comb begin
      state_nxt_s    = state_r;
      ctl_nxt_s      = SYM_IDL;
      byte_cnt_nxt_s = byte_cnt_r;
      pop_s          = 1'b0;
      skp_take_s     = 1'b0;
      case (state_r)
         ST_IDLE, ST_END, ST_EDB: begin
            if (skp_req_s) begin
               state_nxt_s = ST_SKP0;
               ctl_nxt_s   = SYM_COM;
               skp_take_s  = 1'b1;
            end else if (PKT_START && (PKT_LEN != 8'd0)) begin
               state_nxt_s    = ST_STP;
               ctl_nxt_s      = SYM_STP;
               byte_cnt_nxt_s = PKT_LEN;
            end else begin
               state_nxt_s = ST_IDLE;
               ctl_nxt_s   = SYM_IDL;
            end
         end
         ST_SKP0: begin
            state_nxt_s = ST_SKP1;
            ctl_nxt_s   = SYM_SKP;
         end
         ST_SKP1: begin
            state_nxt_s = ST_SKP2;
            ctl_nxt_s   = SYM_SKP;
         end
         ST_SKP2: begin
            state_nxt_s = ST_SKP3;
            ctl_nxt_s   = SYM_SKP;
         end
         ST_SKP3: begin
            state_nxt_s = ST_IDLE;
            ctl_nxt_s   = SYM_IDL;
         end
         ST_STP, ST_DATA: begin
            if ((state_r == ST_DATA) && (byte_cnt_r == 8'd0)) begin
               state_nxt_s = ST_END;
               ctl_nxt_s   = SYM_END;
            end else if (!FIFO_EMPTY) begin
               state_nxt_s    = ST_DATA;
               ctl_nxt_s      = SYM_DATA;
               pop_s          = 1'b1;
               byte_cnt_nxt_s = byte_cnt_r - 8'd1;
            end else begin
               state_nxt_s = ST_EDB;
               ctl_nxt_s   = SYM_EDB;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            ctl_nxt_s   = SYM_IDL;
         end
      endcase
   end

   assign FIFO_RD = pop_s & RESET_L;

   // State, SKP scheduler and registered outputs
   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         state_r       <= ST_IDLE;
         skp_cnt_r     <= {CNT_W{1'b0}};
         skp_pending_r <= 1'b0;
         byte_cnt_r    <= 8'd0;
         control_r     <= SYM_IDL;
         tx_buffer_r   <= 8'd0;
         valid_r       <= 1'b0;
         busy_r        <= 1'b0;
         pkt_done_r    <= 1'b0;
         pkt_abort_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         byte_cnt_r <= byte_cnt_nxt_s;
         control_r  <= ctl_nxt_s;
         skp_cnt_r  <= wrap_s ? {CNT_W{1'b0}} : (skp_cnt_r + CNT_W'(1));
         if (skp_take_s) begin
            skp_pending_r <= 1'b0;
         end else if (wrap_s) begin
            skp_pending_r <= 1'b1;
         end else begin
            skp_pending_r <= skp_pending_r;
         end
         if (pop_s) begin
            tx_buffer_r <= FIFO_DATA;
         end else begin
            tx_buffer_r <= tx_buffer_r;
         end
         valid_r     <= (ctl_nxt_s == SYM_DATA);
         busy_r      <= (state_nxt_s == ST_STP) || (state_nxt_s == ST_DATA);
         pkt_done_r  <= (state_nxt_s == ST_END);
         pkt_abort_r <= (state_nxt_s == ST_EDB);
      end
   end

   assign CONTROL   = control_r;
   assign Tx_Buffer = tx_buffer_r;
   assign VALID     = valid_r;
   assign BUSY      = busy_r;
   assign PKT_DONE  = pkt_done_r;
   assign PKT_ABORT = pkt_abort_r;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer with a show-ahead FIFO model and
// hand-computed per-cycle symbol expectations (SKP_INTERVAL = 16).
module tb_tx_frame_sequencer;

   logic       CLK;
   logic       RESET_L;
   logic       PKT_START;
   logic [7:0] PKT_LEN;
   logic       FIFO_EMPTY;
   logic [7:0] FIFO_DATA;
   logic       FIFO_RD;
   logic [3:0] CONTROL;
   logic [7:0] Tx_Buffer;
   logic       VALID;
   logic       BUSY;
   logic       PKT_DONE;
   logic       PKT_ABORT;

   logic [7:0] fifo_mem [0:255];
   logic [7:0] wr_ptr;
   logic [7:0] rd_ptr  = 8'd0;
   int         pop_cnt = 0;
   int         pops0;
   int         n_cmp   = 0;
   int         n_err   = 0;

   tx_frame_sequencer #(.SKP_INTERVAL(16)) dut (
      .CLK       (CLK),
      .RESET_L   (RESET_L),
      .PKT_START (PKT_START),
      .PKT_LEN   (PKT_LEN),
      .FIFO_EMPTY(FIFO_EMPTY),
      .FIFO_DATA (FIFO_DATA),
      .FIFO_RD   (FIFO_RD),
      .CONTROL   (CONTROL),
      .Tx_Buffer (Tx_Buffer),
      .VALID     (VALID),
      .BUSY      (BUSY),
      .PKT_DONE  (PKT_DONE),
      .PKT_ABORT (PKT_ABORT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Show-ahead FIFO: the head moves at the edge where FIFO_RD is high
   always @(posedge CLK) begin
      if (FIFO_RD) begin
         rd_ptr  <= rd_ptr + 8'd1;
         pop_cnt <= pop_cnt + 1;
      end
   end

   assign FIFO_EMPTY = (rd_ptr == wr_ptr);
   assign FIFO_DATA  = fifo_mem[rd_ptr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   // Wait one edge, then check the symbol and its companion flags
   task automatic tick(input string tag, input logic [3:0] ctl, input logic [7:0] dat);
      @(negedge CLK);
      chk($sformatf("%s.ctl", tag),   {28'd0, CONTROL},   {28'd0, ctl});
      chk($sformatf("%s.valid", tag), {31'd0, VALID},     {31'd0, (ctl == 4'd9)});
      chk($sformatf("%s.busy", tag),  {31'd0, BUSY},      {31'd0, (ctl == 4'd3) || (ctl == 4'd9)});
      chk($sformatf("%s.done", tag),  {31'd0, PKT_DONE},  {31'd0, (ctl == 4'd5)});
      chk($sformatf("%s.abort", tag), {31'd0, PKT_ABORT}, {31'd0, (ctl == 4'd6)});
      if (ctl == 4'd9) begin
         chk($sformatf("%s.data", tag), {24'd0, Tx_Buffer}, {24'd0, dat});
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_L   = 1'b0;
      PKT_START = 1'b0;
      PKT_LEN   = 8'd0;
      wr_ptr    = rd_ptr;
      @(negedge CLK);
      chk("rst.ctl", {28'd0, CONTROL}, 32'd8);
      chk("rst.rd",  {31'd0, FIFO_RD}, 32'd0);
      RESET_L = 1'b1;
   endtask

   initial begin
      logic [3:0] e;
      int         m;

      // Reset held with PKT_START high, then a 4-byte packet
      RESET_L   = 1'b0;
      PKT_START = 1'b1;
      PKT_LEN   = 8'd4;
      wr_ptr    = 8'd0;
      push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rst0.ctl",   {28'd0, CONTROL}, 32'd8);
         chk("rst0.valid", {31'd0, VALID},   32'd0);
         chk("rst0.rd",    {31'd0, FIFO_RD}, 32'd0);
      end
      RESET_L = 1'b1;
      pops0   = pop_cnt;
      tick("sp0", 4'd3, 8'h00);
      chk("sp.rd_first", {31'd0, FIFO_RD}, 32'd1);
      PKT_START = 1'b0;
      tick("sp1", 4'd9, 8'hA1);
      tick("sp2", 4'd9, 8'hB2);
      tick("sp3", 4'd9, 8'hC3);
      tick("sp4", 4'd9, 8'hD4);
      chk("sp.rd_last", {31'd0, FIFO_RD}, 32'd0);
      tick("sp5", 4'd5, 8'h00);
      tick("sp6", 4'd8, 8'h00);
      chk("sp.pops", pop_cnt - pops0, 32'd4);

      // Underrun: 5 requested, 2 available
      do_reset();
      push(8'h11); push(8'h22);
      PKT_START = 1'b1;
      PKT_LEN   = 8'd5;
      pops0     = pop_cnt;
      tick("ur0", 4'd3, 8'h00);
      PKT_START = 1'b0;
      tick("ur1", 4'd9, 8'h11);
      tick("ur2", 4'd9, 8'h22);
      chk("ur.nopop", {31'd0, FIFO_RD}, 32'd0);
      tick("ur3", 4'd6, 8'h00);
      tick("ur4", 4'd8, 8'h00);
      chk("ur.pops", pop_cnt - pops0, 32'd2);

      // Back-to-back: lengths 2, 0 (ignored while busy), 3, then 0 at a decision point
      do_reset();
      push(8'h31); push(8'h32); push(8'h41); push(8'h42); push(8'h43);
      PKT_START = 1'b1;
      PKT_LEN   = 8'd2;
      tick("bb0", 4'd3, 8'h00);
      PKT_LEN = 8'd0;
      tick("bb1", 4'd9, 8'h31);
      tick("bb2", 4'd9, 8'h32);
      PKT_LEN = 8'd3;
      tick("bb3", 4'd5, 8'h00);
      tick("bb4", 4'd3, 8'h00);
      PKT_LEN = 8'd0;
      tick("bb5", 4'd9, 8'h41);
      tick("bb6", 4'd9, 8'h42);
      tick("bb7", 4'd9, 8'h43);
      tick("bb8", 4'd5, 8'h00);
      tick("bb9", 4'd8, 8'h00);
      tick("bb10", 4'd8, 8'h00);
      PKT_START = 1'b0;

      // SKP spacing on an idle link: COM at every 16th edge after release
      do_reset();
      for (int i = 1; i <= 36; i++) begin
         m = i % 16;
         if (m == 0) e = 4'd0;
         else if ((i > 16) && (m <= 3)) e = 4'd2;
         else e = 4'd8;
         tick($sformatf("sk%0d", i), e, 8'h00);
      end

      // SKP deferral: 20-byte packet accepted when the counter is 10
      do_reset();
      for (int b = 0; b < 20; b++) push(8'h50 + 8'(b));
      for (int i = 1; i <= 10; i++) tick($sformatf("df_idl%0d", i), 4'd8, 8'h00);
      PKT_START = 1'b1;
      PKT_LEN   = 8'd20;
      tick("df_stp", 4'd3, 8'h00);
      PKT_START = 1'b0;
      for (int b = 0; b < 20; b++) tick($sformatf("df_d%0d", b), 4'd9, 8'h50 + 8'(b));
      tick("df_end", 4'd5, 8'h00);
      tick("df_com", 4'd0, 8'h00);
      tick("df_s1", 4'd2, 8'h00);
      tick("df_s2", 4'd2, 8'h00);
      tick("df_s3", 4'd2, 8'h00);
      tick("df_i1", 4'd8, 8'h00);
      tick("df_i2", 4'd8, 8'h00);

      // PKT_START coinciding with a wrap in IDLE: SKP goes first
      do_reset();
      for (int i = 1; i <= 15; i++) tick($sformatf("co_idl%0d", i), 4'd8, 8'h00);
      PKT_START = 1'b1;
      PKT_LEN   = 8'd1;
      tick("co_com", 4'd0, 8'h00);
      tick("co_s1", 4'd2, 8'h00);
      tick("co_s2", 4'd2, 8'h00);
      tick("co_s3", 4'd2, 8'h00);
      PKT_START = 1'b0;
      tick("co_i1", 4'd8, 8'h00);
      tick("co_i2", 4'd8, 8'h00);

      // Reset mid-packet: silent abandon, no EDB, no further pops
      do_reset();
      push(8'h61); push(8'h62); push(8'h63);
      PKT_START = 1'b1;
      PKT_LEN   = 8'd3;
      pops0     = pop_cnt;
      tick("mr0", 4'd3, 8'h00);
      PKT_START = 1'b0;
      tick("mr1", 4'd9, 8'h61);
      RESET_L = 1'b0;
      @(negedge CLK);
      chk("mr.ctl",   {28'd0, CONTROL}, 32'd8);
      chk("mr.valid", {31'd0, VALID},   32'd0);
      chk("mr.rd",    {31'd0, FIFO_RD}, 32'd0);
      RESET_L = 1'b1;
      wr_ptr  = rd_ptr;
      tick("mr2", 4'd8, 8'h00);
      tick("mr3", 4'd8, 8'h00);
      chk("mr.pops", pop_cnt - pops0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Transmit framing sequencer for the link-layer TX path. It drives the 4-bit CONTROL select and the 8-bit `Tx_Buffer` byte of the forced-control symbol mux directly downstream, so it decides which symbol goes out each cycle. It frames packets as STP, payload bytes read from a show-ahead TX FIFO, then END. Between packets it emits IDL and periodically inserts a SKP ordered set (COM SKP SKP SKP).

## Interface
Parameters:
- `SKP_INTERVAL`, default 64: cycles between SKP ordered-set requests; legal range 8..1024.

Ports:
- `CLK`  in  1  single clock; all logic on rising edge.
- `RESET_L`  in  1  synchronous, active-low reset.
- `PKT_START`  in  1  request to send one packet; level-sampled.
- `PKT_LEN`  in  8  payload byte count; sampled with an accepted `PKT_START`; 0 is illegal and the request is ignored.
- `FIFO_EMPTY`  in  1  TX FIFO empty flag.
- `FIFO_DATA`  in  8  FIFO head byte; valid whenever `FIFO_EMPTY`=0 (show-ahead).
- `FIFO_RD`  out  1  pop strobe, combinational; the head byte is consumed at the same edge.
- `CONTROL`  out  4  registered symbol select to the mux.
- `Tx_Buffer`  out  8  registered payload byte; meaningful only when `CONTROL`=9.
- `VALID`  out  1  registered; 1 exactly when `CONTROL`=9 (DATA).
- `BUSY`  out  1  1 from packet accept until END is issued.
- `PKT_DONE`  out  1  one-cycle pulse, concurrent with `CONTROL`=END.
- `PKT_ABORT`  out  1  one-cycle pulse, concurrent with `CONTROL`=EDB.

## Operation
- CONTROL encoding (fixed): 0 COM, 1 PAD, 2 SKP, 3 STP, 4 SDP, 5 END, 6 EDB, 7 FTS, 8 IDL, 9 DATA. This block never emits PAD, SDP or FTS.
- Reset values (`RESET_L`=0 at an edge):
  - `CONTROL`=8, `Tx_Buffer`=0.
  - `VALID`, `FIFO_RD`, `BUSY`, `PKT_DONE`, `PKT_ABORT` = 0.
  - State IDLE, SKP counter 0, skp_pending 0, byte counter 0.
  - Reset mid-packet abandons the packet silently: no EDB, no further FIFO pops.
- States: IDLE, SKP0, SKP1, SKP2, SKP3, STP, DATA, END, EDB.
- SKP scheduler:
  - Free-running counter 0..`SKP_INTERVAL`-1, counting in every state.
  - At wrap it sets skp_pending. skp_pending clears on entry to SKP0.
  - A wrap while already pending leaves a single pending request.
- Decision point: the IDLE, END and EDB states. Priority order:
  1. skp_pending → SKP0.
  2. `PKT_START`=1 and `PKT_LEN`≠0 → STP; latch `PKT_LEN` into the byte counter.
  3. Otherwise → IDLE.
- SKP0..SKP3: emit COM, SKP, SKP, SKP, then go to the decision point. SKP is never inserted inside a packet; a pending SKP waits for END or EDB.
- STP: emit STP, then go to DATA. A packet start when `FIFO_EMPTY`=1 is still accepted.
- DATA, each cycle:
  - `FIFO_EMPTY`=0: `FIFO_RD`=1, `Tx_Buffer`←`FIFO_DATA`, `CONTROL`←9, byte counter decrements. When the count reaches 0, go to END.
  - `FIFO_EMPTY`=1 (underrun): go to EDB with no pop. Unsent bytes stay in the FIFO; upstream must flush them.
- END: emit END with `PKT_DONE`. EDB: emit EDB with `PKT_ABORT`. Both are decision points, so back-to-back packets carry no IDL between END and the next STP.
- `BUSY`=1 in STP, DATA and END-pending cycles; `PKT_START` while `BUSY` is ignored.

## Timing
- Outputs are registered: the symbol chosen in cycle n appears on `CONTROL` after edge n. The downstream mux adds one more register.
- Accept at edge k: STP visible after k; data bytes after k+1..k+N; END after k+N+1. There are no bubbles if the FIFO never empties.
- `FIFO_RD` is asserted in the same cycle the byte is latched; at most one pop per cycle; never popped outside DATA.
- Underrun in cycle m: no pop, and EDB is visible after edge m. No DATA cycle precedes EDB when the FIFO is empty at the first DATA cycle.
- Counter wrap and END in the same cycle: pending is set and the next decision point picks SKP0.
- `PKT_START` and wrap coincide in IDLE: SKP0 wins. The packet is accepted at the decision point after SKP3 if `PKT_START` is still high.

## Test plan
- Reset: hold `RESET_L`=0 for 3 cycles with `PKT_START`=1 → `CONTROL`=8, `VALID`=0, `FIFO_RD`=0 throughout; the first STP appears 1 cycle after release.
- Single packet: `PKT_LEN`=4, FIFO preloaded with A1 B2 C3 D4 → `CONTROL` sequence 3,9,9,9,9,5,8; `Tx_Buffer` A1..D4 with `VALID`=1; 4 pops; `PKT_DONE` pulses with END.
- Underrun: `PKT_LEN`=5, only 2 bytes in the FIFO → 3,9,9,6,8; `PKT_ABORT`=1 once; exactly 2 pops.
- SKP spacing: `SKP_INTERVAL`=16, idle link → COM,SKP,SKP,SKP every 16 cycles, IDL otherwise.
- SKP deferral: `SKP_INTERVAL`=16, `PKT_LEN`=20 started at counter 10 → no SKP inside the packet; COM,2,2,2 immediately after END.
- Back-to-back with `PKT_LEN`=0: `PKT_START` held with `PKT_LEN`=2, then 0, then 3 → 3,9,9,5,3,9,9,9,5; the 0-length request produces no symbols.
